// File: rtl/downsizer_rr_sched_if.sv
// Bundles the requester-side handshake, the downsizer port and the beat tags
// of downsizer_rr_sched.
//   sched_en    : new grants allowed when 1
//   req_valid   : per-requester word valid
//   req_data    : packed requester words, requester i at slice i
//   req_ready   : one-hot grant back to the requesters
//   ds_valid_in : word strobe to the downsizer
//   ds_inp_data : word to the downsizer
//   ds_out_en   : beat valid coming back from the downsizer
//   beat_src_id : source id of the current downsizer beat
//   beat_last   : current beat is the last beat of its word
//   busy        : a word is in flight in the downsizer
// The scheduler uses the slave modport. The requester/downsizer side uses the
// master modport.
interface downsizer_rr_sched_if #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2,
    parameter int INP_DATA_WIDTH = 128
);
    logic                              sched_en;
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ*INP_DATA_WIDTH*8-1:0] req_data;
    logic [NUM_REQ-1:0]                req_ready;
    logic                              ds_valid_in;
    logic [INP_DATA_WIDTH*8-1:0]       ds_inp_data;
    logic                              ds_out_en;
    logic [ID_WIDTH-1:0]               beat_src_id;
    logic                              beat_last;
    logic                              busy;

    modport slave (
        input  sched_en, req_valid, req_data, ds_out_en,
        output req_ready, ds_valid_in, ds_inp_data, beat_src_id, beat_last, busy
    );

    modport master (
        output sched_en, req_valid, req_data, ds_out_en,
        input  req_ready, ds_valid_in, ds_inp_data, beat_src_id, beat_last, busy
    );
endinterface

// File: rtl/downsizer_rr_sched.sv
// Round-robin scheduler that shares one 4:1 downsizer between NUM_REQ
// requesters.
// The downsizer has no ready signal, so a grant is issued at most once every
// BEATS cycles. The scheduler then tags each returned beat with its source id
// and a last-beat marker.
// Ports:
//   clk  : clock
//   rstn : asynchronous reset, asserted high (the existing codebase polarity)
//   bus  : slave view of downsizer_rr_sched_if (requesters, downsizer, tags)
module downsizer_rr_sched #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2,
    parameter int INP_DATA_WIDTH = 128,
    parameter int BEATS          = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    downsizer_rr_sched_if.slave  bus
);
    localparam int DW    = INP_DATA_WIDTH * 8;
    localparam int CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(BEATS - 2);

    logic [CNT_W-1:0]    gap_cnt_r;
    logic [ID_WIDTH-1:0] rr_ptr_r;
    logic [ID_WIDTH-1:0] grant_id_r;
    logic                busy_r;
    logic [CNT_W-1:0]    beat_cnt_r;
    logic                beat_last_r;

    logic                found_s;
    logic [ID_WIDTH-1:0] winner_s;
    int                  sum_s;
    int                  idx_s;
    logic                grant_s;
    logic [ID_WIDTH-1:0] rr_next_s;
    logic [NUM_REQ-1:0]  req_ready_s;
    logic [DW-1:0]       ds_data_s;

    // Round-robin search: the first valid requester at or after rr_ptr wins.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        sum_s    = 0;
        idx_s    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s = int'(rr_ptr_r) + k;
            if (sum_s >= NUM_REQ) begin
                idx_s = sum_s - NUM_REQ;
            end else begin
                idx_s = sum_s;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found_s && (idx_s == i) && bus.req_valid[i]) begin
                    found_s  = 1'b1;
                    winner_s = ID_WIDTH'(i);
                end else begin
                    found_s  = found_s;
                    winner_s = winner_s;
                end
            end
        end
    end

    // The grant window is open only out of reset, when enabled, and when the
    // downsizer is on its final beat or is idle.
    always_comb begin
        grant_s     = (!rstn) && bus.sched_en && (gap_cnt_r == '0) && found_s;
        req_ready_s = '0;
        ds_data_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s && (winner_s == ID_WIDTH'(i))) begin
                req_ready_s[i] = 1'b1;
                ds_data_s      = bus.req_data[i*DW +: DW];
            end else begin
                req_ready_s[i] = 1'b0;
                ds_data_s      = ds_data_s;
            end
        end
        if (int'(winner_s) == NUM_REQ - 1) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = winner_s + ID_WIDTH'(1);
        end
    end

    // Grant pacing: gap counter, round-robin pointer and the id of the granted word.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            gap_cnt_r  <= '0;
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
        end else if (grant_s) begin
            gap_cnt_r  <= CNT_LAST;
            rr_ptr_r   <= rr_next_s;
            grant_id_r <= winner_s;
        end else if (gap_cnt_r != '0) begin
            gap_cnt_r  <= gap_cnt_r - CNT_W'(1);
        end else begin
            gap_cnt_r  <= gap_cnt_r;
        end
    end

    // Beat tracking. beat_last is loaded one beat early, so the flop is high
    // exactly during the final beat. A stray ds_out_en while idle is a
    // protocol error and leaves the tags untouched.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            busy_r      <= 1'b0;
            beat_cnt_r  <= '0;
            beat_last_r <= 1'b0;
        end else begin
            if (grant_s) begin
                busy_r <= 1'b1;
            end else if (bus.ds_out_en && busy_r && (beat_cnt_r == CNT_LAST)) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end

            if (bus.ds_out_en && busy_r) begin
                beat_cnt_r  <= (beat_cnt_r == CNT_LAST) ? '0 : beat_cnt_r + CNT_W'(1);
                beat_last_r <= (beat_cnt_r == CNT_PENULT);
            end else if (bus.ds_out_en) begin
                beat_cnt_r  <= beat_cnt_r;
                beat_last_r <= beat_last_r;
            end else begin
                beat_cnt_r  <= beat_cnt_r;
                beat_last_r <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.ds_valid_in = grant_s;
    assign bus.ds_inp_data = ds_data_s;
    assign bus.beat_src_id = grant_id_r;
    assign bus.beat_last   = beat_last_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_downsizer_rr_sched.sv
module tb_downsizer_rr_sched;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int IDW = 128;
    localparam int DW = IDW * 8;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } grant_t;

    logic clk = 1'b0;
    logic rstn;
    logic force_oe;
    int   ds_cnt;
    int   checks = 0;
    int   failures = 0;

    grant_t        gq[$];
    logic [IW:0]   bq[$];

    downsizer_rr_sched_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .INP_DATA_WIDTH(IDW)) bus ();

    downsizer_rr_sched #(.NUM_REQ(NR), .ID_WIDTH(IW), .INP_DATA_WIDTH(IDW), .BEATS(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural downsizer: 4 beats after each accepted word, shares rstn.
    always @(posedge clk or posedge rstn) begin
        if (rstn) ds_cnt <= 0;
        else if (bus.ds_valid_in) ds_cnt <= 4;
        else if (ds_cnt != 0) ds_cnt <= ds_cnt - 1;
    end
    assign bus.ds_out_en = (ds_cnt != 0) | force_oe;

    // Scoreboard monitors: grants and beats are compared against queued expectations.
    always @(negedge clk) begin
        grant_t g;
        logic [IW:0] e;
        if (!rstn) begin
            checks++;
            if ($countones(bus.req_ready) > 1 || bus.ds_valid_in !== (|bus.req_ready)) begin
                failures++;
                $display("FAIL onehot t=%0t req_ready=%b ds_valid_in=%b", $time, bus.req_ready, bus.ds_valid_in);
            end
            if (bus.ds_valid_in) begin
                checks++;
                if (gq.size() == 0) begin
                    failures++;
                    $display("FAIL grant_unexpected t=%0t req_ready=%b expected no grant", $time, bus.req_ready);
                end else begin
                    g = gq.pop_front();
                    if (bus.req_ready !== NR'(1 << g.id) || bus.ds_inp_data !== g.data) begin
                        failures++;
                        $display("FAIL grant t=%0t req_ready=%b expected=%b data_ok=%0d", $time,
                                 bus.req_ready, NR'(1 << g.id), bus.ds_inp_data === g.data);
                    end
                end
            end
            if (bus.ds_out_en && !force_oe) begin
                checks++;
                if (bq.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected t=%0t id=%0d last=%b", $time, bus.beat_src_id, bus.beat_last);
                end else begin
                    e = bq.pop_front();
                    if ({bus.beat_src_id, bus.beat_last} !== e || bus.busy !== 1'b1) begin
                        failures++;
                        $display("FAIL beat t=%0t id/last=%0d/%b expected=%0d/%b busy=%b", $time,
                                 bus.beat_src_id, bus.beat_last, e[IW:1], e[0], bus.busy);
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk_word(int i, int tag);
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = 32'(tag * 4096 + i * 256 + j) ^ 32'hA5A5_0000;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(int id, int tag);
        grant_t g;
        logic [IW:0] e;
        g.id = IW'(id);
        g.data = mk_word(id, tag);
        gq.push_back(g);
        for (int b = 0; b < 4; b++) begin
            e = {IW'(id), (b == 3)};
            bq.push_back(e);
        end
    endtask

    task automatic do_reset(int tag);
        checks++;
        if (gq.size() != 0 || bq.size() != 0) begin
            failures++;
            $display("FAIL drained grants_left=%0d beats_left=%0d expected 0/0", gq.size(), bq.size());
        end
        gq.delete();
        bq.delete();
        rstn = 1'b1;
        force_oe = 1'b0;
        bus.sched_en = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = mk_word(i, tag);
        tick();
        tick();
        rstn = 1'b0;
        bus.sched_en = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        force_oe = 1'b0;
        bus.sched_en = 1'b1;
        bus.req_valid = 4'hF;
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = mk_word(i, 0);
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0000 || bus.ds_valid_in !== 1'b0 || bus.ds_inp_data !== '0) begin
            failures++;
            $display("FAIL reset_grant req_ready=%b ds_valid_in=%b expected 0000/0", bus.req_ready, bus.ds_valid_in);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.beat_src_id !== 2'd0 || bus.beat_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_tags busy=%b id=%0d last=%b expected 0/0/0", bus.busy, bus.beat_src_id, bus.beat_last);
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset(1);
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = (c == 2) ? 4'b0100 : 4'b0000;
            if (c == 2) push_word(2, 1);
            @(negedge clk);
            checks++;
            if (bus.req_ready !== ((c == 2) ? 4'b0100 : 4'b0000)) begin
                failures++;
                $display("FAIL single_ready c=%0d got=%b", c, bus.req_ready);
            end
            if (c >= 3) begin
                checks++;
                if (bus.busy !== (c <= 6)) begin
                    failures++;
                    $display("FAIL single_busy c=%0d got=%b expected=%b", c, bus.busy, c <= 6);
                end
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (bus.beat_src_id !== 2'd2 || bus.beat_last !== (c == 6)) begin
                    failures++;
                    $display("FAIL single_tag c=%0d id=%0d last=%b expected 2/%b", c, bus.beat_src_id, bus.beat_last, c == 6);
                end
            end
            tick();
        end
    endtask

    task automatic test_all_req();
        logic [3:0] exp_rdy;
        do_reset(2);
        for (int c = 0; c < 22; c++) begin
            bus.req_valid = (c <= 16) ? 4'hF : 4'h0;
            exp_rdy = (c % 4 == 0 && c <= 16) ? 4'(1 << ((c / 4) % 4)) : 4'b0000;
            if (exp_rdy != 4'b0000) push_word((c / 4) % 4, 2);
            @(negedge clk);
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL all_ready c=%0d got=%b expected=%b", c, bus.req_ready, exp_rdy);
            end
            if (c >= 1 && c <= 20) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.beat_src_id !== IW'(((c - 1) / 4) % 4) || bus.beat_last !== ((c - 1) % 4 == 3)) begin
                    failures++;
                    $display("FAIL all_stream c=%0d busy=%b id=%0d last=%b expected 1/%0d/%b", c, bus.busy,
                             bus.beat_src_id, bus.beat_last, ((c - 1) / 4) % 4, (c - 1) % 4 == 3);
                end
            end
            if (c == 21) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL all_idle got busy=%b expected 0", bus.busy);
                end
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        int id;
        do_reset(3);
        for (int c = 0; c < 18; c++) begin
            bus.req_valid = (c <= 12) ? 4'b1010 : 4'b0000;
            id = ((c / 4) % 2 == 1) ? 3 : 1;
            exp_rdy = (c % 4 == 0 && c <= 12) ? 4'(1 << id) : 4'b0000;
            if (exp_rdy != 4'b0000) push_word(id, 3);
            @(negedge clk);
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL fair_ready c=%0d got=%b expected=%b", c, bus.req_ready, exp_rdy);
            end
            if (c == 17) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL fair_idle got busy=%b expected 0", bus.busy);
                end
            end
            tick();
        end
    endtask

    task automatic test_sched_en();
        logic [3:0] exp_rdy;
        logic exp_busy;
        do_reset(4);
        for (int c = 0; c < 16; c++) begin
            bus.req_valid = (c <= 10) ? 4'hF : 4'h0;
            bus.sched_en = (c == 0 || c >= 10);
            exp_rdy = (c == 0) ? 4'b0001 : ((c == 10) ? 4'b0010 : 4'b0000);
            exp_busy = (c >= 1 && c <= 4) || (c >= 11 && c <= 14);
            if (c == 0) push_word(0, 4);
            if (c == 10) push_word(1, 4);
            @(negedge clk);
            checks++;
            if (bus.req_ready !== exp_rdy || bus.busy !== exp_busy) begin
                failures++;
                $display("FAIL sched_en c=%0d req_ready=%b busy=%b expected %b/%b", c, bus.req_ready, bus.busy, exp_rdy, exp_busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(5);
        bus.req_valid = 4'b0100;
        push_word(2, 5);
        void'(bq.pop_back());
        void'(bq.pop_back());
        void'(bq.pop_back());
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL rmid_grant got=%b expected=0100", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.beat_src_id !== 2'd2) begin
            failures++;
            $display("FAIL rmid_inflight busy=%b id=%0d expected 1/2", bus.busy, bus.beat_src_id);
        end
        tick();
        rstn = 1'b1;
        bus.req_valid = 4'b0101;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.beat_last !== 1'b0 || bus.beat_src_id !== 2'd0 || bus.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rmid_cleared busy=%b last=%b id=%0d req_ready=%b expected 0/0/0/0000",
                     bus.busy, bus.beat_last, bus.beat_src_id, bus.req_ready);
        end
        tick();
        rstn = 1'b0;
        push_word(0, 5);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rmid_restart got=%b expected=0001", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        for (int c = 4; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== (c <= 7)) begin
                failures++;
                $display("FAIL rmid_busy c=%0d got=%b expected=%b", c, bus.busy, c <= 7);
            end
            tick();
        end
    endtask

    task automatic test_window();
        logic [3:0] exp_rdy;
        int exp_id [3] = '{1, 2, 1};
        do_reset(6);
        for (int c = 0; c < 14; c++) begin
            bus.req_valid = (c > 8) ? 4'b0000 : ((c % 2 == 1) ? 4'b1010 : 4'b0110);
            exp_rdy = (c % 4 == 0 && c <= 8) ? 4'(1 << exp_id[c / 4]) : 4'b0000;
            if (exp_rdy != 4'b0000) push_word(exp_id[c / 4], 6);
            @(negedge clk);
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL window c=%0d got=%b expected=%b", c, bus.req_ready, exp_rdy);
            end
            tick();
        end
    endtask

    task automatic test_protocol_err();
        force_oe = 1'b1;
        @(negedge clk);
        tick();
        force_oe = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.beat_src_id !== 2'd1 || bus.beat_last !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL proto_hold id=%0d last=%b busy=%b expected 1/0/0", bus.beat_src_id, bus.beat_last, bus.busy);
        end
        tick();
        // rr_ptr is 2 after the last window grant; req 0 is the only one valid.
        bus.req_valid = 4'b0001;
        push_word(0, 6);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL proto_next got=%b expected=0001", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        for (int c = 0; c < 6; c++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b1;
        force_oe = 1'b0;
        bus.sched_en = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_all_req();
        test_fairness();
        test_sched_en();
        test_reset_mid();
        test_window();
        test_protocol_err();
        do_reset(7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
